// File: rtl/matrix_addsub_seq.sv
// rtl/matrix_addsub_seq.sv - sequential signed matrix add/subtract, LANES elements per cycle
// Exact result is formed at ELEM_W+1 bits so overflow is judged once, with no separate negate step.
module matrix_addsub_seq #(
  parameter int DIM    = 5,
  parameter int ELEM_W = 8,
  parameter int LANES  = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [1:0]                   op,
  input  logic                         sat_en,
  input  logic [DIM*DIM*ELEM_W-1:0]    mat_a,
  input  logic [DIM*DIM*ELEM_W-1:0]    mat_b,
  output logic                         busy,
  output logic                         done,
  output logic [DIM*DIM*ELEM_W-1:0]    mat_out,
  output logic [DIM*DIM-1:0]           ovf_mask,
  output logic                         overflow
);

  localparam int N  = DIM * DIM;
  localparam int NW = N * ELEM_W;
  localparam int G  = (N + LANES - 1) / LANES;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam logic [ELEM_W-1:0] MAXV = {1'b0, {(ELEM_W-1){1'b1}}};
  localparam logic [ELEM_W-1:0] MINV = {1'b1, {(ELEM_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT             state;
  logic [NW-1:0]     aLat;
  logic [NW-1:0]     bLat;
  logic [1:0]        opLat;
  logic              satLat;
  logic [GW-1:0]     grp;

  int                laneIdx   [LANES];
  int                laneSafe  [LANES];
  logic              laneValid [LANES];
  logic [ELEM_W:0]   laneExact [LANES];
  logic              laneOvf   [LANES];
  logic [ELEM_W-1:0] laneRes   [LANES];

  function automatic logic [ELEM_W:0] exactOf(input logic [1:0] o,
                                              input logic [ELEM_W-1:0] a,
                                              input logic [ELEM_W-1:0] b);
    logic [ELEM_W:0] ea;
    logic [ELEM_W:0] eb;
    ea = {a[ELEM_W-1], a};
    eb = {b[ELEM_W-1], b};
    case (o)
      2'b00:   exactOf = ea + eb;
      2'b01:   exactOf = ea - eb;
      2'b10:   exactOf = eb - ea;
      default: exactOf = '0 - ea;
    endcase
  endfunction

  // Lanes past the last element read element 0 harmlessly and are masked off on write.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      laneIdx[l]   = int'(grp) * LANES + l;
      laneValid[l] = laneIdx[l] < N;
      laneSafe[l]  = laneValid[l] ? laneIdx[l] : 0;
      laneExact[l] = exactOf(opLat, aLat[laneSafe[l]*ELEM_W +: ELEM_W],
                             bLat[laneSafe[l]*ELEM_W +: ELEM_W]);
      laneOvf[l]   = laneExact[l][ELEM_W] ^ laneExact[l][ELEM_W-1];
      laneRes[l]   = (satLat && laneOvf[l]) ? (laneExact[l][ELEM_W] ? MINV : MAXV)
                                            : laneExact[l][ELEM_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      mat_out  <= '0;
      ovf_mask <= '0;
      aLat     <= '0;
      bLat     <= '0;
      opLat    <= 2'b00;
      satLat   <= 1'b0;
      grp      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            aLat     <= mat_a;
            bLat     <= mat_b;
            opLat    <= op;
            satLat   <= sat_en;
            mat_out  <= '0;
            ovf_mask <= '0;
            grp      <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          for (int l = 0; l < LANES; l++) begin
            if (laneValid[l]) begin
              mat_out[laneIdx[l]*ELEM_W +: ELEM_W] <= laneRes[l];
              ovf_mask[laneIdx[l]]                 <= laneOvf[l];
            end
          end
          if (grp == GW'(G - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            grp <= grp + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign overflow = |ovf_mask;

endmodule

// File: tb/tb_matrix_addsub_seq.sv
// tb/tb_matrix_addsub_seq.sv - directed checks of matrix_addsub_seq at LANES=5, 4 and 1
module tb_matrix_addsub_seq;
  localparam int N  = 25;
  localparam int W  = 8;
  localparam int NW = N * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [2:0]    startV;
  logic [1:0]    op;
  logic          sat;
  logic [NW-1:0] matA, matB;
  logic [2:0]    busyV, doneV, ovfV;
  logic [NW-1:0] out0, out1, out2;
  logic [N-1:0]  msk0, msk1, msk2;

  int checks = 0;
  int failures = 0;

  matrix_addsub_seq u0 (
    .clk(clk), .rst_n(rst_n), .start(startV[0]), .op(op), .sat_en(sat), .mat_a(matA), .mat_b(matB),
    .busy(busyV[0]), .done(doneV[0]), .mat_out(out0), .ovf_mask(msk0), .overflow(ovfV[0]));
  matrix_addsub_seq #(.LANES(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(startV[1]), .op(op), .sat_en(sat), .mat_a(matA), .mat_b(matB),
    .busy(busyV[1]), .done(doneV[1]), .mat_out(out1), .ovf_mask(msk1), .overflow(ovfV[1]));
  matrix_addsub_seq #(.LANES(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(startV[2]), .op(op), .sat_en(sat), .mat_a(matA), .mat_b(matB),
    .busy(busyV[2]), .done(doneV[2]), .mat_out(out2), .ovf_mask(msk2), .overflow(ovfV[2]));

  task automatic check(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NW-1:0] outOf(input int w);
    return (w == 0) ? out0 : (w == 1) ? out1 : out2;
  endfunction

  function automatic logic [N-1:0] mskOf(input int w);
    return (w == 0) ? msk0 : (w == 1) ? msk1 : msk2;
  endfunction

  // Reference built on plain integers rather than bit-level tricks.
  task automatic buildExp(output logic [NW-1:0] eo, output logic [N-1:0] em);
    int ia, ib, ex, r;
    for (int k = 0; k < N; k++) begin
      ia = $signed(matA[k*W +: W]);
      ib = $signed(matB[k*W +: W]);
      case (op)
        2'b00:   ex = ia + ib;
        2'b01:   ex = ia - ib;
        2'b10:   ex = ib - ia;
        default: ex = -ia;
      endcase
      em[k] = (ex > 127) || (ex < -128);
      r = (sat && em[k]) ? ((ex > 0) ? 127 : -128) : ex;
      eo[k*W +: W] = r[7:0];
    end
  endtask

  // Called at a falling edge; returns at the falling edge where done is seen (or on timeout).
  task automatic runJob(input int w, output int firstBusy, output int busyCnt, output int doneCyc);
    firstBusy = -1;
    busyCnt = 0;
    doneCyc = -1;
    startV[w] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    startV[w] = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (busyV[w]) begin
        busyCnt++;
        if (firstBusy < 0) firstBusy = c;
      end
      if (doneV[w]) begin
        doneCyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic randOperands();
    for (int k = 0; k < N; k++) begin
      matA[k*W +: W] = 8'($urandom);
      matB[k*W +: W] = 8'($urandom);
    end
    op  = 2'($urandom);
    sat = 1'($urandom);
  endtask

  initial begin
    int fb, bc, dc, seen, gv;
    logic [NW-1:0] eo;
    logic [N-1:0]  em;

    rst_n = 1'b0; startV = '0; op = 2'b00; sat = 1'b0; matA = '0; matB = '0;
    repeat (2) @(negedge clk);
    check("rst busy", NW'(busyV[0]), NW'(0));
    check("rst done", NW'(doneV[0]), NW'(0));
    check("rst out", out0, '0);
    check("rst mask", NW'(msk0), NW'(0));
    check("rst ovf", NW'(ovfV[0]), NW'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: all a=1, b=2
    matA = {N{8'h01}}; matB = {N{8'h02}};
    runJob(0, fb, bc, dc);
    check("t1 first busy", NW'(fb), NW'(1));
    check("t1 busy cycles", NW'(bc), NW'(5));
    check("t1 done cycle", NW'(dc), NW'(6));
    check("t1 out", out0, {N{8'h03}});
    check("t1 ovf", NW'(ovfV[0]), NW'(0));
    @(negedge clk);
    check("t1 done pulse", NW'(doneV[0]), NW'(0));

    // 2: 0 - (-128)
    matA = '0; matB = '0; matB[7:0] = 8'h80; op = 2'b01; sat = 1'b0;
    runJob(0, fb, bc, dc);
    check("t2 wrap out", out0, NW'(8'h80));
    check("t2 wrap mask", NW'(msk0), NW'(1));
    check("t2 wrap ovf", NW'(ovfV[0]), NW'(1));
    sat = 1'b1;
    runJob(0, fb, bc, dc);
    check("t2 sat out", out0, NW'(8'h7F));
    check("t2 sat mask", NW'(msk0), NW'(1));

    // 3: -1 - (-128); B-A; -A with saturation
    matA[7:0] = 8'hFF; matB[7:0] = 8'h80; op = 2'b01; sat = 1'b0;
    runJob(0, fb, bc, dc);
    check("t3 sub out", out0, NW'(8'h7F));
    check("t3 sub mask", NW'(msk0), NW'(0));
    matA[7:0] = 8'd5; matB[7:0] = 8'd3; op = 2'b10;
    runJob(0, fb, bc, dc);
    check("t3 rsub out", out0, NW'(8'hFE));
    matA[7:0] = 8'h80; matB[7:0] = 8'h11; op = 2'b11; sat = 1'b1;
    runJob(0, fb, bc, dc);
    check("t3 neg out", out0, NW'(8'h7F));
    check("t3 neg mask", NW'(msk0), NW'(1));

    // 4: +/-100 + +/-100
    matA = '0; matB = '0;
    matA[7:0] = 8'd100; matB[7:0] = 8'd100; matA[15:8] = 8'h9C; matB[15:8] = 8'h9C;
    op = 2'b00; sat = 1'b1;
    runJob(0, fb, bc, dc);
    check("t4 sat out", out0, NW'(16'h807F));
    check("t4 sat mask", NW'(msk0), NW'(3));
    sat = 1'b0;
    runJob(0, fb, bc, dc);
    check("t4 wrap out", out0, NW'(16'h38C8));
    check("t4 wrap mask", NW'(msk0), NW'(3));

    // 5: start during RUN is ignored
    matA = {N{8'h01}}; matB = {N{8'h02}}; op = 2'b00; sat = 1'b0;
    startV[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    startV[0] = 1'b0;
    @(negedge clk);
    startV[0] = 1'b1; matA = {N{8'h07}};
    @(negedge clk);
    startV[0] = 1'b0;
    dc = -1;
    for (int c = 3; c <= 40; c++) begin
      if (doneV[0]) begin dc = c; break; end
      @(negedge clk);
    end
    check("t5 done cycle", NW'(dc), NW'(6));
    check("t5 out intact", out0, {N{8'h03}});
    @(negedge clk);

    // 5b: reset mid-RUN discards the job
    startV[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    startV[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5 rst busy", NW'(busyV[0]), NW'(0));
    check("t5 rst done", NW'(doneV[0]), NW'(0));
    check("t5 rst out", out0, '0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (doneV[0]) seen++;
    end
    check("t5 no done", NW'(seen), NW'(0));

    // 6: LANES=4 and LANES=1, random operands, back-to-back second job
    for (int w = 1; w <= 2; w++) begin
      gv = (w == 1) ? 7 : 25;
      randOperands();
      buildExp(eo, em);
      runJob(w, fb, bc, dc);
      check($sformatf("t6 l%0d done cycle", w), NW'(dc), NW'(gv + 1));
      check($sformatf("t6 l%0d busy cycles", w), NW'(bc), NW'(gv));
      check($sformatf("t6 l%0d out", w), outOf(w), eo);
      check($sformatf("t6 l%0d mask", w), NW'(mskOf(w)), NW'(em));
      randOperands();
      buildExp(eo, em);
      runJob(w, fb, bc, dc);
      check($sformatf("t6 l%0d b2b first busy", w), NW'(fb), NW'(1));
      check($sformatf("t6 l%0d b2b done cycle", w), NW'(dc), NW'(gv + 1));
      check($sformatf("t6 l%0d b2b out", w), outOf(w), eo);
      check($sformatf("t6 l%0d b2b mask", w), NW'(mskOf(w)), NW'(em));
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
